// File: rtl/multicycle_control_fsm.sv
// Main sequencer for the multicycle RV32I core: steps each instruction through its phases,
// drives datapath selects/strobes, counts retired instructions and traps bad opcodes/memory hangs.
module multicycle_control_fsm #(
  parameter int CNT_W   = 32,
  parameter int TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [6:0]       op,
  input  logic             mem_ready,
  output logic [1:0]       ALUOp,
  output logic [1:0]       ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [1:0]       ResultSrc,
  output logic             AdrSrc,
  output logic             IRWrite,
  output logic             PCUpdate,
  output logic             Branch,
  output logic             RegWrite,
  output logic             MemWrite,
  output logic             illegal,
  output logic [3:0]       state_o,
  output logic [CNT_W-1:0] instret_o
);

  // Handshake: a memory state (FETCH, MEMREAD, MEMWRITE) holds its request until the cycle in
  // which mem_ready is sampled high on the rising edge; that edge completes the access.
  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_JAL      = 4'd9,
    S_BEQ      = 4'd10,
    S_ERROR    = 4'd15
  } state_e;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_RTYPE = 7'b0110011;
  localparam logic [6:0] OP_ITYPE = 7'b0010011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_BEQ   = 7'b1100011;

  localparam int              WD_W     = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(TIMEOUT);

  state_e           state_q, state_d;
  logic [WD_W-1:0]  wd_q, wd_d, wd_inc;
  logic [CNT_W-1:0] instret_q, instret_d;
  logic             illegal_q, illegal_d;
  logic             stalling, timeout_hit, retire;

  // Stall tracking: only the three memory states can wait on mem_ready.
  always_comb begin
    stalling    = (state_q == S_FETCH || state_q == S_MEMREAD || state_q == S_MEMWRITE) && !mem_ready;
    wd_inc      = wd_q + 1'b1;
    timeout_hit = (TIMEOUT != 0) && stalling && (wd_inc >= WD_LIMIT);
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:    if (mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_LOAD, OP_STORE: state_d = S_MEMADR;
          OP_RTYPE:          state_d = S_EXECR;
          OP_ITYPE:          state_d = S_EXECI;
          OP_JAL:            state_d = S_JAL;
          OP_BEQ:            state_d = S_BEQ;
          default:           state_d = S_ERROR;
        endcase
      end
      S_MEMADR:   state_d = (op == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:  if (mem_ready) state_d = S_MEMWB;
      S_MEMWRITE: if (mem_ready) state_d = S_FETCH;
      S_EXECR:    state_d = S_ALUWB;
      S_EXECI:    state_d = S_ALUWB;
      S_MEMWB:    state_d = S_FETCH;
      S_ALUWB:    state_d = S_FETCH;
      S_JAL:      state_d = S_FETCH;
      S_BEQ:      state_d = S_FETCH;
      S_ERROR:    state_d = S_ERROR;
      default:    state_d = S_ERROR;
    endcase
    // A ready in the same cycle already cleared timeout_hit, so it wins over the watchdog.
    if (timeout_hit) state_d = S_ERROR;
  end

  // FETCH is only ever entered from a finishing state, so any entry retires an instruction.
  always_comb begin
    wd_d      = (TIMEOUT != 0 && stalling && state_d == state_q) ? wd_inc : '0;
    retire    = (state_d == S_FETCH) && (state_q != S_FETCH);
    instret_d = retire ? instret_q + CNT_W'(1) : instret_q;
    illegal_d = illegal_q | (state_d == S_ERROR);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_FETCH;
      wd_q      <= '0;
      instret_q <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wd_q      <= wd_d;
      instret_q <= instret_d;
      illegal_q <= illegal_d;
    end
  end

  always_comb begin
    ALUOp     = 2'b00;
    ALUSrcA   = 2'b00;
    ALUSrcB   = 2'b00;
    ResultSrc = 2'b00;
    AdrSrc    = 1'b0;
    IRWrite   = 1'b0;
    PCUpdate  = 1'b0;
    Branch    = 1'b0;
    RegWrite  = 1'b0;
    MemWrite  = 1'b0;
    case (state_q)
      S_FETCH: begin
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        IRWrite   = mem_ready;
        PCUpdate  = mem_ready;
      end
      S_DECODE:   ALUSrcA = 2'b01;
      S_MEMADR:   ALUSrcA = 2'b10;
      S_MEMREAD:  AdrSrc = 1'b1;
      S_MEMWB: begin
        ResultSrc = 2'b01;
        RegWrite  = 1'b1;
      end
      S_MEMWRITE: begin
        AdrSrc   = 1'b1;
        MemWrite = 1'b1;
      end
      S_EXECR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        ALUOp   = 2'b10;
      end
      S_EXECI: begin
        ALUSrcA = 2'b10;
        ALUOp   = 2'b10;
      end
      S_ALUWB:    RegWrite = 1'b1;
      S_JAL: begin
        ALUSrcA  = 2'b01;
        ALUSrcB  = 2'b10;
        PCUpdate = 1'b1;
      end
      S_BEQ: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        ALUOp   = 2'b01;
        Branch  = 1'b1;
      end
      default: ;
    endcase
    // Strobes are killed combinationally so an in-flight access cannot commit during reset.
    if (reset) begin
      IRWrite  = 1'b0;
      PCUpdate = 1'b0;
      Branch   = 1'b0;
      RegWrite = 1'b0;
      MemWrite = 1'b0;
    end
  end

  assign state_o   = state_q;
  assign instret_o = instret_q;
  assign illegal   = illegal_q;

endmodule
